// File: rtl/flash_led_pkg.sv
// rtl/flash_led_pkg.sv - shared encodings for the flowing-LED scheduler
package flash_led_pkg;

  localparam logic [1:0] MODE_STOP   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_LEFT   = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  localparam logic [7:0] LED_END_R = 8'h01;
  localparam logic [7:0] LED_END_L = 8'h80;

  typedef enum logic {
    RUN_PAUSED  = 1'b0,
    RUN_RUNNING = 1'b1
  } run_state_e;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronises and debounces the active-low run/pause key
// press_pulse is high for the one cycle in which key_lvl first reads 0.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_lvl,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          lvl_q, lvl_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    press_d = 1'b0;
    cnt_d   = '0;
    // cnt_q counts consecutive cycles the synced key has disagreed with lvl_q
    if (sync2_q != lvl_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        lvl_d   = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      lvl_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_lvl     = lvl_q;
  assign press_pulse = press_q;

endmodule

// File: rtl/flash_led_sched.sv
// rtl/flash_led_sched.sv - shift strobe and direction scheduler for the flowing-LED shifter
// Mode/speed come from raw switches; a debounced key toggles run/pause.
module flash_led_sched
  import flash_led_pkg::*;
#(
  parameter int   BASE_DIV     = 25_000_000,
  parameter int   DEBOUNCE_CYC = 1_000_000,
  parameter logic RUN_AT_RESET = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode_sw,
  input  logic [1:0] speed_sw,
  input  logic       key_n,
  input  logic [7:0] led_fb,
  output logic       clk_bps,
  output logic       dir,
  output logic       running
);

  localparam int         PW        = $clog2(BASE_DIV << 3);
  localparam run_state_e STATE_RST = RUN_AT_RESET ? RUN_RUNNING : RUN_PAUSED;

  logic [1:0]    mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
  logic [1:0]    speed_s1_q, speed_s1_d, speed_s2_q, speed_s2_d;
  logic [1:0]    mode_prev_q, mode_prev_d, speed_prev_q, speed_prev_d;
  run_state_e    state_q, state_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          clk_bps_q, clk_bps_d;
  logic          dir_q, dir_d;
  logic          running_q, running_d;

  logic          key_lvl;
  logic          press_pulse;
  logic          run_en;
  logic          cfg_chg;
  logic [PW-1:0] period_last;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_lvl    (key_lvl),
    .press_pulse(press_pulse)
  );

  assign period_last = (PW'(BASE_DIV) << speed_s2_q) - PW'(1);

  always_comb begin
    mode_s1_d    = mode_sw;
    mode_s2_d    = mode_s1_q;
    speed_s1_d   = speed_sw;
    speed_s2_d   = speed_s1_q;
    mode_prev_d  = mode_s2_q;
    speed_prev_d = speed_s2_q;

    run_en  = (state_q == RUN_RUNNING) && (mode_s2_q != MODE_STOP);
    cfg_chg = (mode_s2_q != mode_prev_q) || (speed_s2_q != speed_prev_q);

    // A config change restarts the period so the new speed gets a full first interval
    cnt_d     = '0;
    clk_bps_d = 1'b0;
    if (run_en && !cfg_chg) begin
      if (cnt_q == period_last) begin
        clk_bps_d = 1'b1;
      end else begin
        cnt_d = cnt_q + PW'(1);
      end
    end
    running_d = run_en;

    state_d = state_q;
    if (press_pulse && !key_lvl) begin
      state_d = (state_q == RUN_RUNNING) ? RUN_PAUSED : RUN_RUNNING;
    end

    // Bounce only reacts at the exact end patterns; anything else keeps the last direction
    dir_d = dir_q;
    case (mode_s2_q)
      MODE_RIGHT: dir_d = 1'b0;
      MODE_LEFT:  dir_d = 1'b1;
      MODE_BOUNCE: begin
        if (led_fb == LED_END_R) begin
          dir_d = 1'b1;
        end else if (led_fb == LED_END_L) begin
          dir_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_s1_q    <= '0;
      mode_s2_q    <= '0;
      speed_s1_q   <= '0;
      speed_s2_q   <= '0;
      mode_prev_q  <= '0;
      speed_prev_q <= '0;
      state_q      <= STATE_RST;
      cnt_q        <= '0;
      clk_bps_q    <= 1'b0;
      dir_q        <= 1'b0;
      running_q    <= RUN_AT_RESET;
    end else begin
      mode_s1_q    <= mode_s1_d;
      mode_s2_q    <= mode_s2_d;
      speed_s1_q   <= speed_s1_d;
      speed_s2_q   <= speed_s2_d;
      mode_prev_q  <= mode_prev_d;
      speed_prev_q <= speed_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clk_bps_q    <= clk_bps_d;
      dir_q        <= dir_d;
      running_q    <= running_d;
    end
  end

  assign clk_bps = clk_bps_q;
  assign dir     = dir_q;
  assign running = running_q;

endmodule

// File: tb/tb_flash_led_sched.sv
// tb/tb_flash_led_sched.sv - randomized self-checking bench for flash_led_sched
module tb_flash_led_sched;

  localparam int BASE_DIV = 4;
  localparam int DEB      = 8;

  // Behavioural view: inputs as seen 1 and 2 clocks ago, a run of disagreeing key
  // samples, and the number of enabled cycles elapsed in the current strobe period.
  typedef struct packed {
    logic [1:0] mode_d1;
    logic [1:0] mode_d2;
    logic [1:0] speed_d1;
    logic [1:0] speed_d2;
    logic       key_d1;
    logic       key_d2;
    logic [1:0] mode_last;
    logic [1:0] speed_last;
    logic       lvl;
    int         diff_run;
    logic       press;
    logic       run;
    int         elapsed;
    logic       bps;
    logic       dir;
    logic       running;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_sw;
  logic [1:0] speed_sw;
  logic       key_n;
  logic [7:0] led_fb;
  logic       bps_a, dir_a, run_a;
  logic       bps_b, dir_b, run_b;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_bps_a  = 0;
  int   n_bps_b  = 0;
  mdl_t m_a, m_b;

  always #5 clk = ~clk;

  flash_led_sched #(
    .BASE_DIV(BASE_DIV), .DEBOUNCE_CYC(DEB), .RUN_AT_RESET(1'b1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .mode_sw(mode_sw), .speed_sw(speed_sw), .key_n(key_n),
    .led_fb(led_fb), .clk_bps(bps_a), .dir(dir_a), .running(run_a)
  );

  flash_led_sched #(
    .BASE_DIV(BASE_DIV), .DEBOUNCE_CYC(DEB), .RUN_AT_RESET(1'b0)
  ) u_dut_paused (
    .clk(clk), .rst_n(rst_n), .mode_sw(mode_sw), .speed_sw(speed_sw), .key_n(key_n),
    .led_fb(led_fb), .clk_bps(bps_b), .dir(dir_b), .running(run_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_reset(input logic run_at_reset);
    mdl_t m;
    m          = '0;
    m.key_d1   = 1'b1;
    m.key_d2   = 1'b1;
    m.lvl      = 1'b1;
    m.run      = run_at_reset;
    m.running  = run_at_reset;
    return m;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t s, input logic rstn, input logic run_at_reset,
                                    input logic [1:0] mode, input logic [1:0] speed,
                                    input logic key, input logic [7:0] led);
    mdl_t n;
    logic en, chg;
    int   period;
    if (!rstn) return mdl_reset(run_at_reset);
    n      = s;
    en     = s.run && (s.mode_d2 != 2'b00);
    chg    = (s.mode_d2 != s.mode_last) || (s.speed_d2 != s.speed_last);
    period = BASE_DIV << s.speed_d2;

    n.running = en;
    n.bps     = 1'b0;
    if (!en || chg) begin
      n.elapsed = 0;
    end else begin
      n.elapsed = s.elapsed + 1;
      if (n.elapsed == period) begin
        n.bps     = 1'b1;
        n.elapsed = 0;
      end
    end

    if (s.mode_d2 == 2'b01) n.dir = 1'b0;
    else if (s.mode_d2 == 2'b10) n.dir = 1'b1;
    else if (s.mode_d2 == 2'b11 && led == 8'h01) n.dir = 1'b1;
    else if (s.mode_d2 == 2'b11 && led == 8'h80) n.dir = 1'b0;

    if (s.press) n.run = !s.run;
    n.press = 1'b0;
    if (s.key_d2 != s.lvl) begin
      n.diff_run = s.diff_run + 1;
      if (n.diff_run == DEB) begin
        n.lvl      = s.key_d2;
        n.press    = !s.key_d2;
        n.diff_run = 0;
      end
    end else begin
      n.diff_run = 0;
    end

    n.mode_last  = s.mode_d2;
    n.speed_last = s.speed_d2;
    n.mode_d2    = s.mode_d1;
    n.mode_d1    = mode;
    n.speed_d2   = s.speed_d1;
    n.speed_d1   = speed;
    n.key_d2     = s.key_d1;
    n.key_d1     = key;
    return n;
  endfunction

  // One clock: advance both models and the shifter at the edge, compare at the falling edge.
  task automatic tick();
    logic [7:0] led_nxt;
    @(posedge clk);
    led_nxt = led_fb;
    if (m_a.bps) led_nxt = m_a.dir ? {led_fb[6:0], led_fb[7]} : {led_fb[0], led_fb[7:1]};
    m_a = mdl_next(m_a, rst_n, 1'b1, mode_sw, speed_sw, key_n, led_fb);
    m_b = mdl_next(m_b, rst_n, 1'b0, mode_sw, speed_sw, key_n, led_fb);
    @(negedge clk);
    check("bps_a", bps_a, m_a.bps);
    check("dir_a", dir_a, m_a.dir);
    check("running_a", run_a, m_a.running);
    check("bps_b", bps_b, m_b.bps);
    check("dir_b", dir_b, m_b.dir);
    check("running_b", run_b, m_b.running);
    if (bps_a) n_bps_a++;
    if (bps_b) n_bps_b++;
    led_fb = led_nxt;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic press_key();
    key_n = 1'b0;
    run(12);
    key_n = 1'b1;
    run(12);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    m_a = mdl_reset(1'b1);
    m_b = mdl_reset(1'b0);
    check("rst_bps_a", bps_a, m_a.bps);
    check("rst_dir_a", dir_a, m_a.dir);
    check("rst_running_a", run_a, m_a.running);
    check("rst_bps_b", bps_b, m_b.bps);
    check("rst_dir_b", dir_b, m_b.dir);
    check("rst_running_b", run_b, m_b.running);
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (errors so far %0d)", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    rst_n    = 1'b1;
    mode_sw  = 2'b01;
    speed_sw = 2'b00;
    key_n    = 1'b1;
    led_fb   = 8'h80;
    @(negedge clk);
    async_reset();

    // Right mode, fastest speed: a strobe every BASE_DIV cycles
    run(12);
    snap = n_bps_a;
    run(40);
    check("strobes_speed0", n_bps_a - snap, 10);
    check("dir_right", dir_a, 0);
    check("running_right", run_a, 1);

    // Speed 2 gives a 16-cycle period, then drop back to speed 0 mid-count
    speed_sw = 2'b10;
    run(10);
    snap = n_bps_a;
    run(64);
    check("strobes_speed2", n_bps_a - snap, 4);
    run($urandom_range(1, 15));
    speed_sw = 2'b00;
    run(20);

    // Bounce from the left end: walk down to 01, back up, never wrapping
    mode_sw = 2'b00;
    run(6);
    led_fb  = 8'h80;
    mode_sw = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      logic [7:0] prev;
      logic [7:0] exp_led;
      int waited;
      int t;
      prev   = led_fb;
      waited = 0;
      while (led_fb == prev && waited < 12) begin
        tick();
        waited++;
      end
      t       = k % 14;
      exp_led = 8'h01 << ((t <= 7) ? 7 - t : t - 7);
      check("bounce_led", led_fb, exp_led);
    end

    // A 3-cycle glitch is ignored; a 12-cycle press pauses
    mode_sw = 2'b01;
    run(10);
    key_n = 1'b0;
    run(3);
    key_n = 1'b1;
    run(5);
    check("glitch_ignored", run_a, 1);
    key_n = 1'b0;
    run(12);
    key_n = 1'b1;
    run(4);
    snap = n_bps_a;
    run(20);
    check("paused_no_strobe", n_bps_a - snap, 0);
    check("paused_running", run_a, 0);
    press_key();
    check("resumed_running", run_a, 1);

    // Stop mode holds direction and silences strobes; left mode resumes them
    mode_sw = 2'b00;
    run(4);
    snap = n_bps_a;
    run(20);
    check("stop_no_strobe", n_bps_a - snap, 0);
    check("stop_running", run_a, 0);
    check("stop_dir_held", dir_a, 0);
    mode_sw = 2'b10;
    run(4);
    check("left_dir", dir_a, 1);
    run(20);

    // Reset mid-period while the RUN_AT_RESET=0 instance is running
    press_key();
    mode_sw  = 2'b01;
    speed_sw = 2'b01;
    run(13);
    check("pre_reset_running_b", run_b, 1);
    async_reset();
    snap = n_bps_b;
    run(40);
    check("post_reset_no_strobe_b", n_bps_b - snap, 0);
    check("post_reset_running_b", run_b, 0);

    // Randomized segments of switch settings, key activity, odd LED patterns and resets
    for (int seg = 0; seg < 40; seg++) begin
      int len;
      int kstart;
      int klen;
      int sel;
      mode_sw  = 2'($urandom_range(0, 3));
      speed_sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) led_fb = 8'($urandom);
      len    = $urandom_range(8, 80);
      kstart = $urandom_range(0, len);
      sel    = $urandom_range(0, 2);
      klen   = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(1, 6) : $urandom_range(9, 14);
      for (int c = 0; c < len; c++) begin
        key_n = !(c >= kstart && c < kstart + klen);
        tick();
      end
      key_n = 1'b1;
      if ($urandom_range(0, 9) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
